// File: rtl/i2c_slave_rx_if.sv
// Bus bundle between the I2C edge/condition detector and the write-only slave receiver.
interface i2c_slave_rx_if #(
  parameter int CNT_W = 8
);
  logic             sda_in;
  logic             start_in;
  logic             stop_in;
  logic             scl_rise_in;
  logic             scl_fall_in;
  logic             sda_oe_out;
  logic [7:0]       rx_data_out;
  logic             rx_valid_out;
  logic             addr_match_out;
  logic             busy_out;
  logic [CNT_W-1:0] byte_cnt_out;

  modport master (
    output sda_in, start_in, stop_in, scl_rise_in, scl_fall_in,
    input  sda_oe_out, rx_data_out, rx_valid_out, addr_match_out, busy_out, byte_cnt_out
  );

  modport slave (
    input  sda_in, start_in, stop_in, scl_rise_in, scl_fall_in,
    output sda_oe_out, rx_data_out, rx_valid_out, addr_match_out, busy_out, byte_cnt_out
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: address match, open-drain ACK, one-cycle data pulses.
// All outputs registered (one cycle after the causing strobe); no backpressure, every data byte is ACKed.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         CNT_W      = 8
) (
  input logic           clk,
  input logic           rst,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, ACK_SETUP, ACK_DRIVE, WAIT_STOP
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data, rx_data_nxt;
  logic             rx_valid, rx_valid_nxt;
  logic             sda_oe, sda_oe_nxt;
  logic             addr_match, addr_match_nxt;
  logic             busy;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]       byte_in;

  assign byte_in = {shreg[6:0], bus.sda_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      sda_oe     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      sda_oe     <= sda_oe_nxt;
      addr_match <= addr_match_nxt;
      busy       <= (state_nxt != IDLE);
      byte_cnt   <= byte_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = 1'b0;
    sda_oe_nxt     = sda_oe;
    addr_match_nxt = addr_match;
    byte_cnt_nxt   = byte_cnt;

    if (bus.start_in) begin
      state_nxt      = ADDR;
      bit_cnt_nxt    = '0;
      shreg_nxt      = '0;
      byte_cnt_nxt   = '0;
      addr_match_nxt = 1'b0;
      sda_oe_nxt     = 1'b0;
    end else if (bus.stop_in) begin
      state_nxt      = IDLE;
      sda_oe_nxt     = 1'b0;
      addr_match_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (bus.scl_rise_in) begin
            shreg_nxt = byte_in;
            // bit_cnt parks at 7 on the last bit; ACK_DRIVE clears it for the next byte
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                state_nxt = (byte_in == {SLAVE_ADDR, 1'b0}) ? ACK_SETUP : WAIT_STOP;
              end else begin
                rx_data_nxt  = byte_in;
                rx_valid_nxt = 1'b1;
                if (byte_cnt != {CNT_W{1'b1}}) byte_cnt_nxt = byte_cnt + 1'b1;
                state_nxt = ACK_SETUP;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        ACK_SETUP: begin
          if (bus.scl_fall_in) begin
            sda_oe_nxt     = 1'b1;
            addr_match_nxt = 1'b1;
            state_nxt      = ACK_DRIVE;
          end
        end
        ACK_DRIVE: begin
          if (bus.scl_fall_in) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = DATA;
          end
        end
        WAIT_STOP: sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.sda_oe_out     = sda_oe;
  assign bus.rx_data_out    = rx_data;
  assign bus.rx_valid_out   = rx_valid;
  assign bus.addr_match_out = addr_match;
  assign bus.busy_out       = busy;
  assign bus.byte_cnt_out   = byte_cnt;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: table vectors, corner sequences and random transfers against a transfer-level model.
module tb_i2c_slave_rx;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_slave_rx_if #(.CNT_W(CW)) bus ();
  i2c_slave_rx #(.SLAVE_ADDR(7'h48), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic       exp_match;
  int         exp_cnt;

  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       match;
    int         cnt;
  } vec_t;
  vec_t vecs[5];

  always @(negedge clk) if (bus.rx_valid_out === 1'b1) got_q.push_back(bus.rx_data_out);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start_in = 1'b1; tick(); bus.start_in = 1'b0; tick();
  endtask

  task automatic do_stop();
    bus.stop_in = 1'b1; tick(); bus.stop_in = 1'b0; tick();
  endtask

  task automatic scl_bit(input logic v);
    bus.sda_in = v; tick();
    bus.scl_rise_in = 1'b1; tick(); bus.scl_rise_in = 1'b0; tick();
    bus.scl_fall_in = 1'b1; tick(); bus.scl_fall_in = 1'b0; tick();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) scl_bit(b[7-i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    send_bits(b, 7);
    check("oe_before_ack", bus.sda_oe_out, 0);
    scl_bit(b[0]);
    check("ack_on", bus.sda_oe_out, ack);
    bus.sda_in = 1'b1; tick();
    bus.scl_rise_in = 1'b1; tick(); bus.scl_rise_in = 1'b0; tick();
    check("ack_hold", bus.sda_oe_out, ack);
    bus.scl_fall_in = 1'b1; tick(); bus.scl_fall_in = 1'b0; tick();
    check("ack_off", bus.sda_oe_out, 0);
  endtask

  // Transfer-level reference: only a write to 0x48 is acknowledged and delivers its data.
  task automatic model(input logic [7:0] addr);
    exp_match = (addr == {7'h48, 1'b0});
    exp_q.delete();
    if (exp_match) foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
    exp_cnt = !exp_match ? 0 : (tx_q.size() > MAXC ? MAXC : tx_q.size());
  endtask

  task automatic do_xfer(input logic [7:0] addr, input logic match, input int cnt);
    got_q.delete();
    do_start();
    check("busy_after_start", bus.busy_out, 1);
    check("cnt_after_start", bus.byte_cnt_out, 0);
    check("match_after_start", bus.addr_match_out, 0);
    send_byte(addr, match);
    check("addr_match", bus.addr_match_out, match);
    foreach (tx_q[i]) send_byte(tx_q[i], match);
    check("byte_cnt", bus.byte_cnt_out, cnt);
    check("pulse_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("pulse_data", got_q[i], exp_q[i]);
    check("busy_before_stop", bus.busy_out, 1);
    do_stop();
    check("busy_after_stop", bus.busy_out, 0);
    check("match_after_stop", bus.addr_match_out, 0);
    check("oe_after_stop", bus.sda_oe_out, 0);
    check("cnt_held_after_stop", bus.byte_cnt_out, cnt);
  endtask

  initial begin
    vecs[0] = '{addr: 8'h90, n: 1, d0: 8'hA5, d1: 8'h00, match: 1'b1, cnt: 1};
    vecs[1] = '{addr: 8'h92, n: 2, d0: 8'h11, d1: 8'h22, match: 1'b0, cnt: 0};
    vecs[2] = '{addr: 8'h91, n: 0, d0: 8'h00, d1: 8'h00, match: 1'b0, cnt: 0};
    vecs[3] = '{addr: 8'h90, n: 2, d0: 8'h00, d1: 8'hFF, match: 1'b1, cnt: 2};
    vecs[4] = '{addr: 8'h20, n: 1, d0: 8'h5A, d1: 8'h00, match: 1'b0, cnt: 0};

    bus.sda_in = 1'b1; bus.start_in = 1'b0; bus.stop_in = 1'b0;
    bus.scl_rise_in = 1'b0; bus.scl_fall_in = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("rst_oe", bus.sda_oe_out, 0);
    check("rst_valid", bus.rx_valid_out, 0);
    check("rst_data", bus.rx_data_out, 0);
    check("rst_match", bus.addr_match_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_cnt", bus.byte_cnt_out, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      tx_q.delete();
      if (vecs[v].n > 0) tx_q.push_back(vecs[v].d0);
      if (vecs[v].n > 1) tx_q.push_back(vecs[v].d1);
      exp_q.delete();
      if (vecs[v].match) foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
      do_xfer(vecs[v].addr, vecs[v].match, vecs[v].cnt);
    end

    // SCL activity while idle must be ignored
    got_q.delete();
    send_bits(8'h90, 8);
    check("idle_busy", bus.busy_out, 0);
    check("idle_oe", bus.sda_oe_out, 0);
    check("idle_pulses", got_q.size(), 0);

    // Partial byte then repeated START
    got_q.delete();
    do_start();
    send_byte(8'h90, 1'b1);
    send_byte(8'h55, 1'b1);
    check("rs_cnt_before", bus.byte_cnt_out, 1);
    send_bits(8'hFF, 3);
    do_start();
    check("rs_cnt_cleared", bus.byte_cnt_out, 0);
    check("rs_match_cleared", bus.addr_match_out, 0);
    check("rs_no_partial_pulse", got_q.size(), 1);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    check("rs_cnt_after", bus.byte_cnt_out, 1);
    check("rs_data", bus.rx_data_out, 8'h3C);
    check("rs_pulses", got_q.size(), 2);
    do_stop();

    // STOP while driving the ACK
    do_start();
    send_bits(8'h90, 8);
    check("ackdrv_oe_on", bus.sda_oe_out, 1);
    bus.stop_in = 1'b1; tick(); bus.stop_in = 1'b0;
    check("ackdrv_stop_oe", bus.sda_oe_out, 0);
    check("ackdrv_stop_busy", bus.busy_out, 0);
    tick();

    // START and STOP together: START wins
    bus.start_in = 1'b1; bus.stop_in = 1'b1; tick();
    bus.start_in = 1'b0; bus.stop_in = 1'b0;
    check("startstop_busy", bus.busy_out, 1);
    tick();
    do_stop();

    // Reset in the middle of a data byte
    do_start();
    send_byte(8'h90, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_bits(8'hF0, 4);
    bus.scl_fall_in = 1'b1;
    send_bits(8'h00, 0);
    rst = 1'b1; tick(); bus.scl_fall_in = 1'b0;
    check("midrst_oe", bus.sda_oe_out, 0);
    check("midrst_data", bus.rx_data_out, 0);
    check("midrst_match", bus.addr_match_out, 0);
    check("midrst_busy", bus.busy_out, 0);
    check("midrst_cnt", bus.byte_cnt_out, 0);
    rst = 1'b0; tick();
    tx_q.delete(); tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    model(8'h90);
    do_xfer(8'h90, exp_match, exp_cnt);

    // Byte counter saturation
    tx_q.delete();
    for (int i = 0; i < MAXC + 2; i++) tx_q.push_back(8'($urandom));
    model(8'h90);
    do_xfer(8'h90, exp_match, exp_cnt);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0: a = 8'h90;
        1: a = 8'h91;
        2: a = 8'h92;
        default: a = 8'($urandom);
      endcase
      tx_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) tx_q.push_back(8'($urandom));
      model(a);
      do_xfer(a, exp_match, exp_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
